// File: rtl/control_unit.sv
// control_unit -- micro-sequencer of the simple CPU.
//
// Walks fetch (F1..F3), decode (DEC) and up to three execute states (E1..E3)
// for the opcode presented on ir_data, and drives the datapath control word.
//
// Ports
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous active-low reset
//   start            in   leave IDLE and begin fetching
//   ir_data          in   opcode from the instruction register
//   acc_neg          in   ACC sign bit, consulted by JMPGEZ in E1
//   control_signals  out  control word
//                         [0] PC+1        [1] MBR addr->PC  [2] PC->MAR
//                         [3] mem->MBR    [4] MBR->mem      [5] MBR addr->MAR
//                         [6] MBR->IR     [7] ACC->MBR      [8] MBR->BR
//                         [9] ALU->ACC    [12:10] alu_op    [15:13] zero
//   halted           out  high while in HALT
//   illegal_op       out  one-cycle pulse in DEC for an unknown opcode
//   fsm_state        out  current state encoding
module control_unit #(
  parameter int OP_W = 8,
  parameter int CS_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OP_W-1:0] ir_data,
  input  logic            acc_neg,
  output logic [CS_W-1:0] control_signals,
  output logic            halted,
  output logic            illegal_op,
  output logic [3:0]      fsm_state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F1   = 4'd1,
    S_F2   = 4'd2,
    S_F3   = 4'd3,
    S_DEC  = 4'd4,
    S_E1   = 4'd5,
    S_E2   = 4'd6,
    S_E3   = 4'd7,
    S_HALT = 4'd8
  } state_e;

  localparam logic [OP_W-1:0] OP_NOP    = OP_W'('h00);
  localparam logic [OP_W-1:0] OP_STORE  = OP_W'('h01);
  localparam logic [OP_W-1:0] OP_LOAD   = OP_W'('h02);
  localparam logic [OP_W-1:0] OP_ADD    = OP_W'('h03);
  localparam logic [OP_W-1:0] OP_SUB    = OP_W'('h04);
  localparam logic [OP_W-1:0] OP_JMPGEZ = OP_W'('h05);
  localparam logic [OP_W-1:0] OP_JMP    = OP_W'('h06);
  localparam logic [OP_W-1:0] OP_HALT   = OP_W'('h07);
  localparam logic [OP_W-1:0] OP_AND    = OP_W'('h08);
  localparam logic [OP_W-1:0] OP_OR     = OP_W'('h09);
  localparam logic [OP_W-1:0] OP_NOT    = OP_W'('h0A);
  localparam logic [OP_W-1:0] OP_SHR    = OP_W'('h0B);
  localparam logic [OP_W-1:0] OP_SHL    = OP_W'('h0C);

  // Memory-operand ALU ops: fetch operand into BR, then ALU->ACC.
  function automatic logic is_mem_alu(input logic [OP_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND)  || (op == OP_OR);
  endfunction

  function automatic logic is_unary(input logic [OP_W-1:0] op);
    return (op == OP_NOT) || (op == OP_SHR) || (op == OP_SHL);
  endfunction

  function automatic logic is_known(input logic [OP_W-1:0] op);
    return (op == OP_NOP) || (op == OP_STORE) || (op == OP_JMPGEZ) ||
           (op == OP_JMP) || (op == OP_HALT) || is_mem_alu(op) || is_unary(op);
  endfunction

  function automatic logic [2:0] alu_op_f(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD:  return 3'd1;
      OP_SUB:  return 3'd2;
      OP_AND:  return 3'd3;
      OP_OR:   return 3'd4;
      OP_NOT:  return 3'd5;
      OP_SHR:  return 3'd6;
      OP_SHL:  return 3'd7;
      default: return 3'd0;   // LOAD passes B straight through
    endcase
  endfunction

  // Control word for the state about to be entered. JMPGEZ's PC load is not
  // produced here; it is gated by acc_neg live during E1 (see output).
  function automatic logic [CS_W-1:0] cw_f(input state_e s, input logic [OP_W-1:0] op);
    logic [CS_W-1:0] cw;
    cw = '0;
    case (s)
      S_F1: cw[2] = 1'b1;
      S_F2: begin cw[3] = 1'b1; cw[0] = 1'b1; end
      S_F3: begin cw[6] = 1'b1; cw[5] = 1'b1; end
      S_E1: begin
        if (op == OP_STORE)    cw[7] = 1'b1;
        if (is_mem_alu(op))    cw[3] = 1'b1;
        if (op == OP_JMP)      cw[1] = 1'b1;
        if (is_unary(op)) begin
          cw[9]     = 1'b1;
          cw[12:10] = alu_op_f(op);
        end
      end
      S_E2: begin
        if (op == OP_STORE)    cw[4] = 1'b1;
        if (is_mem_alu(op))    cw[8] = 1'b1;
      end
      S_E3: begin
        cw[9]     = 1'b1;
        cw[12:10] = alu_op_f(op);
      end
      default: cw = '0;
    endcase
    return cw;
  endfunction

  state_e          state_q, state_d;
  logic [CS_W-1:0] cs_q, cs_d;
  logic            halted_q, halted_d;
  logic            gez_q, gez_d;     // in E1 of a JMPGEZ

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_F1;
      S_F1:   state_d = S_F2;
      S_F2:   state_d = S_F3;
      S_F3:   state_d = S_DEC;
      S_DEC: begin
        if (ir_data == OP_HALT)                        state_d = S_HALT;
        else if (ir_data == OP_NOP || !is_known(ir_data)) state_d = S_F1;
        else                                           state_d = S_E1;
      end
      S_E1:   state_d = (ir_data == OP_STORE || is_mem_alu(ir_data)) ? S_E2 : S_F1;
      S_E2:   state_d = (ir_data == OP_STORE) ? S_F1 : S_E3;
      S_E3:   state_d = S_F1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // ir_data is stable from DEC onward, so the next-state word can be
    // computed a cycle early and registered.
    cs_d     = cw_f(state_d, ir_data);
    halted_d = (state_d == S_HALT);
    gez_d    = (state_d == S_E1) && (ir_data == OP_JMPGEZ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cs_q     <= '0;
      halted_q <= 1'b0;
      gez_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cs_q     <= cs_d;
      halted_q <= halted_d;
      gez_q    <= gez_d;
    end
  end

  // IR only settles at the F3->DEC edge, so the illegal flag cannot be
  // precomputed; it is decoded from the state register and the live IR.
  assign illegal_op      = (state_q == S_DEC) && !is_known(ir_data);
  assign control_signals = cs_q | (CS_W'(gez_q && !acc_neg) << 1);
  assign halted          = halted_q;
  assign fsm_state       = state_q;

endmodule
